bram_ecc_decoder: RTL and testbench
===================================

# bram_ecc_decoder

SECDED check-and-correct stage for 64-bit words read back from BRAM, the receive-side counterpart of the shared 72-bit (64 data + 8 check) ECC encoder. Recomputes check bits, forms the syndrome, corrects any single-bit error in data or check bits, and flags double or other uncorrectable errors. It is a 2-stage pipeline with valid/ready on both sides, saturating error counters and a sticky first-error log. It sits between BRAM read ports (cache/register file/DRAM buffer) and their consumers.

## Interface
- TAG_W, 16: width of the opaque tag (address/thread id) carried alongside each word.
- CNT_W, 16: width of each saturating error counter.

- gclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept the input word this cycle
- in_data  in  64  received data
- in_ecc  in  8  received check bits
- in_tag  in  TAG_W  tag carried with the word
- out_valid  out  1  corrected word valid
- out_ready  in  1  consumer accepts the output word
- out_data  out  64  corrected data
- out_tag  out  TAG_W  tag of the output word
- out_status  out  2  0 NONE, 1 SBE_DATA, 2 SBE_CHECK, 3 UNCORR
- out_syndrome  out  8  {parity mismatch, syndrome[6:0]}
- cnt_clr  in  1  clear counters and the error log
- sbe_cnt  out  CNT_W  single-bit errors corrected (data or check)
- ue_cnt  out  CNT_W  uncorrectable errors
- log_valid  out  1  error log holds an entry
- log_tag, log_status, log_syndrome  out  TAG_W/2/8  first error since reset/clear

## Operation
- Stage 1 (syndrome): s[6:0] = encoder(in_data)[6:0] ^ in_ecc[6:0]; p = XOR of all 64 data bits and all 8 received check bits. Register data, tag, s, p.
- Hamming layout: check bit i sits at position 2^i (i=0..6); data bits d=0..63 occupy the non-power-of-two positions 3,5,6,7,9,…,71 in ascending order (d0→3, d1→5, d2→6, d3→7, d4→9, d63→71). Check bit 7 is overall parity.
- Stage 2 (classify/correct):
  - s==0, p==0: NONE, data unchanged.
  - p==1, s==0: SBE_CHECK (check bit 7).
  - p==1, s a power of two: SBE_CHECK (check bit log2 s); data unchanged.
  - p==1, s in 3..71, not a power of two: SBE_DATA; flip the data bit mapped to position s.
  - p==1, s>71: UNCORR; data passed uncorrected.
  - p==0, s!=0: UNCORR (double error); data passed uncorrected.
- Counters update on output transfer (out_valid & out_ready) only: SBE_DATA/SBE_CHECK → sbe_cnt+1, UNCORR → ue_cnt+1. Saturate at 2^CNT_W−1; no wrap.
- Error log: on the first transferred word with status≠NONE while log_valid==0, capture tag/status/{p,s} and set log_valid. Later errors do not overwrite.
- cnt_clr: counters and log_valid go to 0 next cycle; clear wins over a same-cycle increment or capture (that event is lost).

## Timing
- Latency 2 cycles input transfer → out_valid; throughput 1 word/cycle with out_ready held high.
- s2_en = ~out_valid | out_ready; s1_en = ~s1_valid | s2_en; in_ready = s1_en (combinational backward path, no bubbles).
- Output holds data/tag/status/syndrome stable while out_valid & ~out_ready.
- Reset: both stage valids, out_valid, sbe_cnt, ue_cnt, log_valid = 0; out_data, out_tag, out_status, out_syndrome, log fields = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation drops in-flight words; nothing is counted for them.

## Structure
- Shared package (libstd): ecc_status_t enum (NONE/SBE_DATA/SBE_CHECK/UNCORR), syndrome-position-to-data-bit function, reuse of the existing 64-bit encoder function for recompute.
- One sub-module: ecc_err_log (saturating counters + sticky first-error log), driven by the output transfer strobe and cnt_clr.

## Test plan
- data 64'h0, ecc 8'h00 → out_data 0, NONE, syndrome 8'h00, counters unchanged, after exactly 2 cycles.
- data 64'h1, ecc 8'h00 (d0 flipped) → out_data 0, SBE_DATA, syndrome 8'h83, sbe_cnt=1, log_valid=1 with that tag.
- data 64'h0, ecc 8'h80 → out_data 0, SBE_CHECK, syndrome 8'h80; ecc 8'h04 → SBE_CHECK, syndrome 8'h84.
- data 64'h3, ecc 8'h00 → UNCORR, syndrome 8'h06, data 64'h3 passed through, ue_cnt=1; log keeps earlier entry.
- Back-to-back stream of 8 words with out_ready toggling 1,0,0,1… → no word lost/duplicated, order and tags preserved, outputs stable during stall.
- CNT_W=2, 5 SBEs → sbe_cnt saturates at 3; cnt_clr together with an SBE transfer → sbe_cnt=0, log_valid=0.

Source files
------------

// File: rtl/bram_ecc_decoder_pkg.sv
// Shared SECDED definitions for the 72-bit (64 data + 8 check) BRAM code:
// status encoding, check-bit encoder and syndrome-to-data-bit mapping.
package bram_ecc_decoder_pkg;

    typedef enum logic [1:0] {
        ECC_NONE      = 2'd0,
        ECC_SBE_DATA  = 2'd1,
        ECC_SBE_CHECK = 2'd2,
        ECC_UNCORR    = 2'd3
    } ecc_status_t;

    // Data bit d sits at the d-th non-power-of-two Hamming position (3,5,6,7,9..71).
    // Check bit 7 is overall parity across data and check bits 0..6.
    function automatic logic [7:0] ecc_encode64(input logic [63:0] data);
        logic [6:0] c;
        int         d;
        c = '0;
        d = 0;
        for (int k = 1; k < 72; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (data[d[5:0]]) c = c ^ k[6:0];
                d++;
            end
        end
        return {(^data) ^ (^c), c};
    endfunction

    // Position s (3..71, not a power of two) maps to data bit s - 1 - #powers_of_two <= s.
    function automatic logic [5:0] ecc_syn_to_bit(input logic [6:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (int'(s) >= (1 << i)) n++;
        end
        return 6'(int'(s) - 1 - n);
    endfunction

endpackage

// File: rtl/bram_ecc_decoder_if.sv
// Word stream into and out of the ECC decoder.
// A word moves on a side when valid & ready are both high at the clock edge; the
// sender holds valid and payload steady until then, ready may depend on valid.
interface bram_ecc_decoder_if #(parameter int TAG_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [7:0]       in_ecc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_status;
    logic [7:0]       out_syndrome;

    modport master (
        output in_valid, in_data, in_ecc, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_status, out_syndrome
    );

    modport slave (
        input  in_valid, in_data, in_ecc, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_status, out_syndrome
    );
endinterface

// File: rtl/ecc_err_log.sv
// Saturating single/uncorrectable error counters plus a sticky first-error log,
// advanced only on output transfers; clear takes priority over any same-cycle event.
module ecc_err_log
    import bram_ecc_decoder_pkg::*;
#(
    parameter int TAG_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             xfer_i,
    input  logic             clr_i,
    input  ecc_status_t      status_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [7:0]       syn_i,
    output logic [CNT_W-1:0] sbe_cnt_o,
    output logic [CNT_W-1:0] ue_cnt_o,
    output logic             log_valid_o,
    output logic [TAG_W-1:0] log_tag_o,
    output ecc_status_t      log_status_o,
    output logic [7:0]       log_syn_o
);
    logic [CNT_W-1:0] sbe_cnt_q, ue_cnt_q;
    logic             log_valid_q;
    logic [TAG_W-1:0] log_tag_q;
    ecc_status_t      log_status_q;
    logic [7:0]       log_syn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sbe_cnt_q    <= '0;
            ue_cnt_q     <= '0;
            log_valid_q  <= 1'b0;
            log_tag_q    <= '0;
            log_status_q <= ECC_NONE;
            log_syn_q    <= '0;
        end else if (xfer_i) begin
            if ((status_i == ECC_SBE_DATA || status_i == ECC_SBE_CHECK) && sbe_cnt_q != '1)
                sbe_cnt_q <= sbe_cnt_q + CNT_W'(1);
            if (status_i == ECC_UNCORR && ue_cnt_q != '1)
                ue_cnt_q <= ue_cnt_q + CNT_W'(1);
            if (!log_valid_q && status_i != ECC_NONE) begin
                log_valid_q  <= 1'b1;
                log_tag_q    <= tag_i;
                log_status_q <= status_i;
                log_syn_q    <= syn_i;
            end
        end
    end

    assign sbe_cnt_o    = sbe_cnt_q;
    assign ue_cnt_o     = ue_cnt_q;
    assign log_valid_o  = log_valid_q;
    assign log_tag_o    = log_tag_q;
    assign log_status_o = log_status_q;
    assign log_syn_o    = log_syn_q;
endmodule

// File: rtl/bram_ecc_decoder.sv
// Two-stage SECDED check-and-correct for 64-bit BRAM read data: stage 1 forms the
// syndrome and overall parity, stage 2 classifies, corrects and presents the word.
module bram_ecc_decoder
    import bram_ecc_decoder_pkg::*;
#(
    parameter int TAG_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             gclk,
    input  logic             rst,
    bram_ecc_decoder_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sbe_cnt,
    output logic [CNT_W-1:0] ue_cnt,
    output logic             log_valid,
    output logic [TAG_W-1:0] log_tag,
    output logic [1:0]       log_status,
    output logic [7:0]       log_syndrome
);
    logic             s1_valid_q;
    logic [63:0]      s1_data_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [6:0]       s1_syn_q;
    logic             s1_par_q;

    logic             out_valid_q;
    logic [63:0]      out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    ecc_status_t      out_status_q;
    logic [7:0]       out_syn_q;

    logic        s1_en, s2_en;
    logic [7:0]  enc;
    ecc_status_t status_d;
    logic [63:0] data_d;
    logic [5:0]  bit_idx;
    logic        syn_pow2;

    // Backward enable chain: a stage loads whenever it is empty or drains this cycle.
    assign s2_en        = ~out_valid_q | bus.out_ready;
    assign s1_en        = ~s1_valid_q | s2_en;
    assign bus.in_ready = s1_en;

    assign enc = ecc_encode64(bus.in_data);

    always_ff @(posedge gclk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_q <= bus.in_data;
                s1_tag_q  <= bus.in_tag;
                s1_syn_q  <= enc[6:0] ^ bus.in_ecc[6:0];
                s1_par_q  <= (^bus.in_data) ^ (^bus.in_ecc);
            end
        end
    end

    assign syn_pow2 = (s1_syn_q & (s1_syn_q - 7'd1)) == 7'd0;
    assign bit_idx  = ecc_syn_to_bit(s1_syn_q);

    always_comb begin
        status_d = ECC_NONE;
        data_d   = s1_data_q;
        if (s1_par_q) begin
            if (syn_pow2) begin
                status_d = ECC_SBE_CHECK;
            end else if (s1_syn_q > 7'd71) begin
                status_d = ECC_UNCORR;
            end else begin
                status_d        = ECC_SBE_DATA;
                data_d[bit_idx] = ~s1_data_q[bit_idx];
            end
        end else if (s1_syn_q != 7'd0) begin
            status_d = ECC_UNCORR;
        end
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_status_q <= ECC_NONE;
            out_syn_q    <= '0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q   <= data_d;
                out_tag_q    <= s1_tag_q;
                out_status_q <= status_d;
                out_syn_q    <= {s1_par_q, s1_syn_q};
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_tag      = out_tag_q;
    assign bus.out_status   = out_status_q;
    assign bus.out_syndrome = out_syn_q;

    ecc_status_t log_status_w;

    ecc_err_log #(.TAG_W(TAG_W), .CNT_W(CNT_W)) u_err_log (
        .clk_i        (gclk),
        .rst_i        (rst),
        .xfer_i       (out_valid_q & bus.out_ready),
        .clr_i        (cnt_clr),
        .status_i     (out_status_q),
        .tag_i        (out_tag_q),
        .syn_i        (out_syn_q),
        .sbe_cnt_o    (sbe_cnt),
        .ue_cnt_o     (ue_cnt),
        .log_valid_o  (log_valid),
        .log_tag_o    (log_tag),
        .log_status_o (log_status_w),
        .log_syn_o    (log_syndrome)
    );

    assign log_status = log_status_w;
endmodule

// File: tb/tb_bram_ecc_decoder.sv
// Directed-vector bench for bram_ecc_decoder: single words with hand-computed
// syndromes, a stalled back-to-back stream, counter saturation and clear.
module tb_bram_ecc_decoder;
    localparam int TAG_W = 16;
    localparam int CNT_W = 2;

    logic             gclk;
    logic             rst;
    logic             cnt_clr;
    logic [CNT_W-1:0] sbe_cnt, ue_cnt;
    logic             log_valid;
    logic [TAG_W-1:0] log_tag;
    logic [1:0]       log_status;
    logic [7:0]       log_syndrome;

    bram_ecc_decoder_if #(.TAG_W(TAG_W)) bus ();

    bram_ecc_decoder #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .gclk         (gclk),
        .rst          (rst),
        .bus          (bus),
        .cnt_clr      (cnt_clr),
        .sbe_cnt      (sbe_cnt),
        .ue_cnt       (ue_cnt),
        .log_valid    (log_valid),
        .log_tag      (log_tag),
        .log_status   (log_status),
        .log_syndrome (log_syndrome)
    );

    // clock / reset
    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [79:0] exp_q[$];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drives one word into an empty pipeline and checks it after exactly two edges;
    // optionally pulses cnt_clr in the cycle the word transfers out.
    task automatic single_word(input string name, input logic [63:0] d, input logic [7:0] e,
                               input logic [15:0] t, input logic [63:0] exp_d,
                               input logic [1:0] exp_st, input logic [7:0] exp_syn,
                               input bit clr_at_out);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_ecc    = e;
        bus.in_tag    = t;
        bus.out_ready = 1'b1;
        @(negedge gclk);
        bus.in_valid = 1'b0;
        check({name, " valid@1"}, 80'(bus.out_valid), 80'd0);
        @(negedge gclk);
        check({name, " valid@2"}, 80'(bus.out_valid), 80'd1);
        check({name, " data"}, 80'(bus.out_data), 80'(exp_d));
        check({name, " tag"}, 80'(bus.out_tag), 80'(t));
        check({name, " status"}, 80'(bus.out_status), 80'(exp_st));
        check({name, " syndrome"}, 80'(bus.out_syndrome), 80'(exp_syn));
        if (clr_at_out) cnt_clr = 1'b1;
        @(negedge gclk);
        cnt_clr = 1'b0;
    endtask

    task automatic check_counts(input string name, input int sbe, input int ue, input bit lv);
        check({name, " sbe_cnt"}, 80'(sbe_cnt), 80'(sbe));
        check({name, " ue_cnt"}, 80'(ue_cnt), 80'(ue));
        check({name, " log_valid"}, 80'(log_valid), 80'(lv));
    endtask

    logic [63:0] s_data [3];
    logic [7:0]  s_ecc  [3];

    initial begin
        s_data[0] = 64'h0; s_ecc[0] = 8'h00;
        s_data[1] = 64'h1; s_ecc[1] = 8'h83;
        s_data[2] = 64'h3; s_ecc[2] = 8'h06;

        rst = 1'b1;
        cnt_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_ecc = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge gclk);
        @(negedge gclk);
        rst = 1'b0;
        check("rst in_ready", 80'(bus.in_ready), 80'd1);
        check("rst out_valid", 80'(bus.out_valid), 80'd0);
        check("rst out_data", 80'(bus.out_data), 80'd0);
        check("rst out_status", 80'(bus.out_status), 80'd0);
        check("rst out_syndrome", 80'(bus.out_syndrome), 80'd0);
        check("rst log_tag", 80'(log_tag), 80'd0);
        check_counts("rst", 0, 0, 1'b0);

        single_word("clean0", 64'h0, 8'h00, 16'h0001, 64'h0, 2'd0, 8'h00, 1'b0);
        check_counts("clean0", 0, 0, 1'b0);
        single_word("d0flip", 64'h1, 8'h00, 16'h0101, 64'h0, 2'd1, 8'h83, 1'b0);
        check_counts("d0flip", 1, 0, 1'b1);
        check("d0flip log_tag", 80'(log_tag), 80'h0101);
        check("d0flip log_status", 80'(log_status), 80'd1);
        check("d0flip log_syn", 80'(log_syndrome), 80'h83);
        single_word("c7flip", 64'h0, 8'h80, 16'h0102, 64'h0, 2'd2, 8'h80, 1'b0);
        check_counts("c7flip", 2, 0, 1'b1);
        single_word("c2flip", 64'h0, 8'h04, 16'h0103, 64'h0, 2'd2, 8'h84, 1'b0);
        check_counts("c2flip", 3, 0, 1'b1);
        single_word("double", 64'h3, 8'h00, 16'h0104, 64'h3, 2'd3, 8'h06, 1'b0);
        check_counts("double", 3, 1, 1'b1);
        check("double log_tag kept", 80'(log_tag), 80'h0101);
        single_word("d2flip", 64'h5, 8'h83, 16'h0105, 64'h1, 2'd1, 8'h86, 1'b0);
        check_counts("d2flip sat", 3, 1, 1'b1);
        single_word("d63flip", 64'h8000_0000_0000_0000, 8'h00, 16'h0106, 64'h0, 2'd1, 8'hC7, 1'b0);
        check_counts("d63flip sat", 3, 1, 1'b1);
        single_word("syn73", 64'h0, 8'h49, 16'h0107, 64'h0, 2'd3, 8'hC9, 1'b0);
        check_counts("syn73", 3, 2, 1'b1);
        single_word("clean1", 64'h1, 8'h83, 16'h0108, 64'h1, 2'd0, 8'h00, 1'b0);
        check_counts("clean1", 3, 2, 1'b1);

        begin : stream
            int   sent = 0;
            int   got = 0;
            bit   stalled = 1'b0;
            logic [79:0] held = '0;
            logic [79:0] exp;
            for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
                @(negedge gclk);
                bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                if (sent < 8) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = s_data[sent % 3];
                    bus.in_ecc   = s_ecc[sent % 3];
                    bus.in_tag   = 16'(16'h5000 + sent);
                end else begin
                    bus.in_valid = 1'b0;
                end
                #1;
                if (stalled) check("stall hold", {bus.out_tag, bus.out_data}, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stream extra word", {bus.out_tag, bus.out_data}, 80'd0 - 80'd1);
                    end else begin
                        exp = exp_q.pop_front();
                        check("stream word", {bus.out_tag, bus.out_data}, exp);
                        check("stream status", 80'(bus.out_status), 80'd0);
                    end
                    got++;
                end
                stalled = bus.out_valid && !bus.out_ready;
                held = {bus.out_tag, bus.out_data};
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back({bus.in_tag, bus.in_data});
                    sent++;
                end
            end
            bus.in_valid = 1'b0;
            check("stream count", 80'(got), 80'd8);
            check("stream queue empty", 80'(exp_q.size()), 80'd0);
            @(negedge gclk);
            check_counts("stream", 3, 2, 1'b1);
        end

        single_word("clr+sbe", 64'h1, 8'h00, 16'h0A0A, 64'h0, 2'd1, 8'h83, 1'b1);
        check_counts("clr+sbe", 0, 0, 1'b0);
        single_word("after clr", 64'h10, 8'h00, 16'h0B0B, 64'h0, 2'd1, 8'h89, 1'b0);
        check_counts("after clr", 1, 0, 1'b1);
        check("after clr log_tag", 80'(log_tag), 80'h0B0B);
        check("after clr log_syn", 80'(log_syndrome), 80'h89);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
